// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path.
// Contents:
//   DATA_W, ADDR_W - register width and register address width
//   REG_ZERO       - address of the hard-wired zero register
//   req_idx_t      - writeback requester index (0 = ALU, 1 = LOAD)
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. This block is purely combinational.
// When both requesters are valid, the one that was not granted last wins.
// Ports:
//   valid[1:0] - request lines (bit 0 = ALU, bit 1 = LOAD)
//   hold       - resource unavailable this cycle; nothing is granted
//   last_grant - index granted on the most recent transfer
//   grant[1:0] - one-hot (or zero) grant
module rr_arb2
    import rf_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       hold,
    input  req_idx_t   last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: defaulting every output before the branches keeps this block
        // free of inferred latches when no case matches.
        grant = 2'b00;
        if (!hold) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == REQ_ALU) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-bank write port between two writeback
// requesters (req0 = ALU result, req1 = memory load) with round robin. The
// accepted write is registered and presented to the bank one cycle later.
// The block also flags pending writes to the two decode read addresses so
// that decode can stall on RAW hazards.
// Ports:
//   clk, rst_n             - clock (rising edge), synchronous active-low reset
//   hold                   - bank unavailable; no grants this cycle
//   reqN_valid/ready       - per-requester handshake (ready is combinational)
//   reqN_addr/data         - destination register and write data
//   RegEn/WriteReg/WriteData - registered bank write port
//   ReadReg1/2, Busy1/2    - hazard query addresses and their pending flags
//   conflict_cnt           - saturating count of contended, unheld cycles
module reg_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W       = rf_pkg::DATA_W,
    parameter int ADDR_W       = rf_pkg::ADDR_W,
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              RegEn,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              Busy1,
    output logic              Busy2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    req_idx_t          last_grant;
    logic [1:0]        grant;
    logic              xfer0;
    logic              xfer1;
    logic              conflict;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .hold       (hold),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // The readys are held low during reset so that nothing is accepted
    // while the output stage is being cleared.
    assign req0_ready = grant[0] & rst_n;
    assign req1_ready = grant[1] & rst_n;

    assign xfer0    = req0_valid & req0_ready;
    assign xfer1    = req1_valid & req1_ready;
    assign conflict = req0_valid & req1_valid & ~hold;

    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (xfer1) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so that every register
        // samples pre-edge values, whatever order the statements are in.
        if (!rst_n) begin
            RegEn        <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            last_grant   <= REQ_LOAD;  // req0 wins the first conflict
            conflict_cnt <= '0;
        end else begin
            if (xfer0 || xfer1) begin
                // A protected write to r0 still completes its handshake and
                // updates the address/data registers, but is never enabled.
                RegEn      <= !(ZERO_PROTECT && (sel_addr == ZERO_ADDR));
                WriteReg   <= sel_addr;
                WriteData  <= sel_data;
                last_grant <= xfer1 ? REQ_LOAD : REQ_ALU;
            end else begin
                RegEn <= 1'b0;
            end

            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    // The RegEn term covers the write that the bank has not yet committed.
    assign Busy1 = (ReadReg1 != ZERO_ADDR) &&
                   ((req0_valid && (req0_addr == ReadReg1)) ||
                    (req1_valid && (req1_addr == ReadReg1)) ||
                    (RegEn      && (WriteReg  == ReadReg1)));

    assign Busy2 = (ReadReg2 != ZERO_ADDR) &&
                   ((req0_valid && (req0_addr == ReadReg2)) ||
                    (req1_valid && (req1_addr == ReadReg2)) ||
                    (RegEn      && (WriteReg  == ReadReg2)));

endmodule
